// File: rtl/ram_copy_dma_if.sv
// rtl/ram_copy_dma_if.sv - RAM port bundle between the copy engine (master) and the 32x32 RAM (slave)
interface ram_copy_dma_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          cen;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  modport master (output cen, output wen, output addr, output din, input dout);
  modport slave  (input cen, input wen, input addr, input din, output dout);
endinterface

// File: rtl/ram_copy_dma.sv
// rtl/ram_copy_dma.sv - in-RAM block copy engine, 2 cycles/word; optional running checksum under RAM_COPY_CSUM_EN
module ram_copy_dma #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int LW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  ram_copy_dma_if.master ram
`ifdef RAM_COPY_CSUM_EN
  , output logic [DW-1:0] csum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] cnt_inc;
  logic          cen_c, wen_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] din_c;
  logic          busy_c, done_c;
`ifdef RAM_COPY_CSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  assign cnt_inc = cnt_q + LW'(1);

  // State and latched copy arguments; everything returns to zero/IDLE on reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
`ifdef RAM_COPY_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifdef RAM_COPY_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next state plus RAM strobes decoded from the current state; reset silences the RAM port at once
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    cen_c   = 1'b0;
    wen_c   = 1'b0;
    addr_c  = '0;
    din_c   = '0;
    busy_c  = (state_q != S_IDLE);
    done_c  = 1'b0;
`ifdef RAM_COPY_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          cnt_d   = '0;
          state_d = (len == '0) ? S_DONE : S_RD;
`ifdef RAM_COPY_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_RD: begin
        cen_c   = 1'b1;
        addr_c  = src_q + cnt_q[AW-1:0];
        state_d = S_WR;
      end
      S_WR: begin
        // The word read in RD is on dout now, so it is written straight back out
        cen_c   = 1'b1;
        wen_c   = 1'b1;
        addr_c  = dst_q + cnt_q[AW-1:0];
        din_c   = ram.dout;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? S_DONE : S_RD;
`ifdef RAM_COPY_CSUM_EN
        csum_d  = csum_q + ram.dout;
`endif
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!reset_n) begin
      cen_c  = 1'b0;
      wen_c  = 1'b0;
      addr_c = '0;
      din_c  = '0;
      busy_c = 1'b0;
      done_c = 1'b0;
    end
  end

  assign ram.cen  = cen_c;
  assign ram.wen  = wen_c;
  assign ram.addr = addr_c;
  assign ram.din  = din_c;
  assign busy     = busy_c;
  assign done     = done_c;
`ifdef RAM_COPY_CSUM_EN
  assign csum     = csum_q;
`endif

endmodule
